fetch_queue: RTL

//  Instruction-fetch front end feeding the IF/ID pipeline register (first_reg). Owns the fetch PC,

---
 rtl/fetch_queue.sv | 123 ++++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, runs a single-outstanding req/ack to imem and
// queues {pc, pc+4, instr} for decode. Optional zero-latency bypass: define FETCH_QUEUE_BYPASS_EN.
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_redirect,
  input  logic [31:0]              i_redirect_pc,
  input  logic                     i_stall,
  output logic                     o_imem_req,
  output logic [31:0]              o_imem_addr,
  input  logic                     i_imem_ack,
  input  logic [31:0]              i_imem_rdata,
  output logic                     o_vld,
  output logic [31:0]              o_instr,
  output logic [31:0]              o_pc,
  output logic [31:0]              o_pc_four,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  state_t          state, state_nxt;
  logic [31:0]     fetch_pc;
  logic [31:0]     req_addr;
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count;
  logic [31:0]     q_instr   [DEPTH];
  logic [31:0]     q_pc      [DEPTH];
  logic [31:0]     q_pc_four [DEPTH];
  logic            issue, push, pop, bypass;

  always_comb begin
    issue = (state == IDLE) && (count < CW'(DEPTH)) && !i_redirect;
`ifdef FETCH_QUEUE_BYPASS_EN
    bypass = (state == WAIT) && i_imem_ack && (count == '0) && !i_stall && !i_redirect;
`else
    bypass = 1'b0;
`endif
    push = (state == WAIT) && i_imem_ack && !i_redirect && !bypass;
    pop  = (count != '0) && !i_stall && !i_redirect;
  end

  // A request already presented to imem cannot be withdrawn, so a redirect while waiting
  // parks in DROP until the stale ack arrives.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (issue) state_nxt = WAIT;
      WAIT: begin
        if (i_imem_ack)      state_nxt = IDLE;
        else if (i_redirect) state_nxt = DROP;
      end
      DROP: if (i_imem_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_addr <= RESET_PC;
    end else begin
      state <= state_nxt;
      if (i_redirect)
        fetch_pc <= {i_redirect_pc[31:2], 2'b00};
      else if ((state == WAIT) && i_imem_ack)
        fetch_pc <= fetch_pc + 32'd4;
      if (issue)
        req_addr <= fetch_pc;
    end
  end

  // Storage is cleared on flush so no stale PC survives a redirect on the head outputs.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        q_instr[i]   <= '0;
        q_pc[i]      <= '0;
        q_pc_four[i] <= '0;
      end
    end else if (i_redirect) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        q_instr[i]   <= '0;
        q_pc[i]      <= '0;
        q_pc_four[i] <= '0;
      end
    end else begin
      if (push) begin
        q_instr[wr_ptr]   <= i_imem_rdata;
        q_pc[wr_ptr]      <= req_addr;
        q_pc_four[wr_ptr] <= req_addr + 32'd4;
        wr_ptr            <= wr_ptr + AW'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_comb begin
    o_imem_req  = (state != IDLE);
    o_imem_addr = (state == IDLE) ? fetch_pc : req_addr;
    o_count     = count;
    o_vld       = (count != '0) || bypass;
    o_instr     = bypass ? i_imem_rdata      : q_instr[rd_ptr];
    o_pc        = bypass ? req_addr          : q_pc[rd_ptr];
    o_pc_four   = bypass ? req_addr + 32'd4  : q_pc_four[rd_ptr];
  end

endmodule
